hilo_muldiv_sequencer: RTL and testbench

- Iterative multiply sequencer that owns the HiLo register-write path for MULTU/MADDU in the pipelined MIPS core.
- Accepts a start from the EX stage and runs a radix-2 shift-add multiply over WIDTH cycles. For MADDU it adds an optional accumulate into {Hi,Lo}, then issues a one-cycle HiLo write.
- Generates the stall that holds IF/ID/EX while a new multiply or an mfhi/mflo would otherwise conflict with an in-flight operation.

---
 rtl/hilo_muldiv_sequencer_if.sv | 35 +++
 rtl/hilo_muldiv_sequencer.sv | 126 ++++++++++++
 tb/tb_hilo_muldiv_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_sequencer_if
// Purpose  : EX-stage request / HiLo write-back bundle for the multiply sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface hilo_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] hi_in;
  logic [WIDTH-1:0] lo_in;
  logic             mf_req;
  logic             abort;
  logic             busy;
  logic             stall;
  logic             hilo_we;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             done;

  modport master (
    output start, op, dataA, dataB, hi_in, lo_in, mf_req, abort,
    input  busy, stall, hilo_we, hi_out, lo_out, done
  );

  modport slave (
    input  start, op, dataA, dataB, hi_in, lo_in, mf_req, abort,
    output busy, stall, hilo_we, hi_out, lo_out, done
  );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_sequencer
// Purpose  : Radix-2 shift-add MULTU/MADDU engine owning the HiLo write path.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  hilo_muldiv_sequencer_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [2*WIDTH-1:0] prod_q,     prod_d;
  logic [2*WIDTH-1:0] acc_q,      acc_d;
  logic [WIDTH-1:0]   mcand_q,    mcand_d;
  logic [WIDTH-1:0]   mplier_q,   mplier_d;
  logic [WIDTH-1:0]   hi_q,       hi_d;
  logic [WIDTH-1:0]   lo_q,       lo_d;
  logic               is_maddu_q, is_maddu_d;
  logic [WIDTH:0]     sum;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_maddu_d = is_maddu_q;
    sum        = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{mplier_q[0]}} & mcand_q};

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort && !bus.op[1]) begin
          mcand_d    = bus.dataA;
          mplier_d   = bus.dataB;
          prod_d     = '0;
          cnt_d      = '0;
          acc_d      = {bus.hi_in, bus.lo_in};
          is_maddu_d = bus.op[0];
          state_d    = S_MUL;
        end
      end
      S_MUL: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          // Carry out of the partial sum becomes the new MSB as the product shifts right.
          prod_d   = {sum, prod_q[WIDTH-1:1]};
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = is_maddu_q ? S_ACC : S_DONE;
          end
        end
      end
      S_ACC: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          prod_d  = prod_q + acc_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // DONE is only ever entered once per op, so this captures the final result.
    if (state_d == S_DONE) begin
      hi_d = prod_d[2*WIDTH-1:WIDTH];
      lo_d = prod_d[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_maddu_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_maddu_q <= is_maddu_d;
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.stall   = bus.busy & (bus.start | bus.mf_req);
  assign bus.hilo_we = (state_q == S_DONE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.hi_out  = hi_q;
  assign bus.lo_out  = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv_sequencer
// Purpose  : Scoreboard bench for the HiLo multiply sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_sequencer;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   pass_cnt;
  logic [2*WIDTH-1:0] sb[$];

  hilo_muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

  hilo_muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Every HiLo write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && bus.hilo_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_we", 64'd1, 64'd0);
      end else begin
        chk("hilo", {bus.hi_out, bus.lo_out}, sb.pop_front());
        chk("done_with_we", {63'd0, bus.done}, 64'd1);
      end
    end
  end

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    if (op == 2'b01) p = p + {hi, lo};
    return p;
  endfunction

  // Called just after a rising edge with the sequencer idle; returns in the cycle after DONE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo);
    int lat;
    bus.op = op; bus.dataA = a; bus.dataB = b; bus.hi_in = hi; bus.lo_in = lo;
    bus.start = 1'b1;
    sb.push_back(model(op, a, b, hi, lo));
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
    lat = 0;
    while (!bus.hilo_we && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, (op == 2'b01) ? WIDTH + 1 : WIDTH);
    @(posedge clk); #1;
    chk("idle_after_done", {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, rh, rl;
    logic [1:0]  rop;
    int          c;
    chk_cnt = 0; pass_cnt = 0;
    bus.start = 0; bus.op = 0; bus.dataA = 0; bus.dataB = 0;
    bus.hi_in = 0; bus.lo_in = 0; bus.mf_req = 0; bus.abort = 0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_we", {62'd0, bus.hilo_we, bus.done}, 64'd0);
    chk("rst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(2'b00, 32'd3, 32'd5, 32'd0, 32'd0);
    chk("multu_3x5", {bus.hi_out, bus.lo_out}, 64'h0000_0000_0000_000F);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    chk("multu_max", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'b01, 32'd2, 32'd3, 32'd0, 32'hFFFF_FFFF);
    chk("maddu_carry", {bus.hi_out, bus.lo_out}, 64'h0000_0001_0000_0005);
    run_op(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // mf_req held, plus a colliding start while busy.
    bus.op = 2'b00; bus.dataA = 32'h1234; bus.dataB = 32'h10; bus.start = 1'b1;
    sb.push_back(64'h12340);
    @(posedge clk); #1;
    bus.start = 1'b0;
    c = 1;
    while (!bus.hilo_we && c < 100) begin
      if (c == 5) bus.mf_req = 1'b1;
      if (c == 10) begin
        bus.dataA = 32'hDEAD; bus.dataB = 32'hBEEF; bus.start = 1'b1;
        #0 chk("stall_on_start", {63'd0, bus.stall}, 64'd1);
      end
      if (c == 11) bus.start = 1'b0;
      if (c == 8) chk("stall_mf", {63'd0, bus.stall}, 64'd1);
      @(posedge clk); #1;
      c++;
    end
    chk("mf_latency", c, WIDTH + 1);
    chk("stall_in_done", {63'd0, bus.stall}, 64'd1);
    @(posedge clk); #1;
    chk("stall_after_done", {63'd0, bus.stall}, 64'd0);
    bus.mf_req = 1'b0;

    // Abort mid-MUL: no write, previous result retained.
    bus.dataA = 32'd9; bus.dataB = 32'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_idle", {63'd0, bus.busy}, 64'd0);
    repeat (40) begin @(posedge clk); #1; end
    chk("abort_keep", {bus.hi_out, bus.lo_out}, 64'h12340);

    // Reserved op and start+abort are both ignored in IDLE.
    bus.op = 2'b10; bus.start = 1'b1;
    @(posedge clk); #1;
    chk("reserved_op", {63'd0, bus.busy}, 64'd0);
    bus.op = 2'b00; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort", {63'd0, bus.busy}, 64'd0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rh = $urandom; rl = $urandom;
      rop = {1'b0, i[0]};
      run_op(rop, ra, rb, rh, rl);
    end

    // Asynchronous reset mid-MUL.
    bus.op = 2'b00; bus.dataA = 32'd100; bus.dataB = 32'd100; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    chk("async_busy", {63'd0, bus.busy}, 64'd0);
    chk("async_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    repeat (40) begin @(posedge clk); #1; end
    run_op(2'b00, 32'd7, 32'd6, 32'd0, 32'd0);
    chk("post_rst_7x6", {bus.hi_out, bus.lo_out}, 64'h2A);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    chk("global_timeout", 64'd0, 64'd1);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
